// File: rtl/digdar_trigger_gen.sv
// Hysteresis threshold trigger: N consecutive excited samples detect, trig_o pulses 1+delay_i clocks later.
// No backpressure; invalid sample cycles are skipped, and enable_i low forces re-arming via relaxation.
module digdar_trigger_gen #(
    parameter int WIDTH = 14,
    parameter int DLY_W = 32
) (
    input  logic                    adc_clk_i,
    input  logic                    adc_rstn_i,
    input  logic                    enable_i,
    input  logic                    clear_i,
    input  logic signed [WIDTH-1:0] sample_i,
    input  logic                    sample_valid_i,
    input  logic signed [WIDTH-1:0] thresh_excite_i,
    input  logic signed [WIDTH-1:0] thresh_relax_i,
    input  logic        [7:0]       latency_i,
    input  logic        [DLY_W-1:0] delay_i,
    output logic                    trig_o,
    output logic        [1:0]       state_o,
    output logic        [31:0]      trig_count_o,
    output logic        [DLY_W-1:0] trig_period_o
);

    typedef enum logic [1:0] {
        RELAXED    = 2'd0,
        EXCITING   = 2'd1,
        DELAYING   = 2'd2,
        WAIT_RELAX = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         ecnt_q, ecnt_d;
    logic [DLY_W-1:0]   dcnt_q, dcnt_d;
    logic               trig_q, trig_d;
    logic [31:0]        count_q, count_d;
    logic [DLY_W-1:0]   period_q, period_d;
    logic [DLY_W-1:0]   pcnt_q, pcnt_d;

    logic               rising;
    logic               excited;
    logic               relaxed;
    logic [7:0]         lat_eff;
    logic [8:0]         ecnt_inc;
    logic               detect;

    assign rising   = (thresh_excite_i >= thresh_relax_i);
    assign excited  = rising ? (sample_i >= thresh_excite_i) : (sample_i <= thresh_excite_i);
    assign relaxed  = rising ? (sample_i <= thresh_relax_i)  : (sample_i >= thresh_relax_i);
    assign lat_eff  = (latency_i == 8'd0) ? 8'd1 : latency_i;
    assign ecnt_inc = {1'b0, ecnt_q} + 9'd1;

    always_comb begin
        state_d = state_q;
        ecnt_d  = ecnt_q;
        dcnt_d  = dcnt_q;
        trig_d  = 1'b0;
        detect  = 1'b0;

        case (state_q)
            RELAXED: begin
                ecnt_d = 8'd0;
                if (sample_valid_i && excited) begin
                    ecnt_d = 8'd1;
                    if (lat_eff == 8'd1) detect = 1'b1;
                    else                 state_d = EXCITING;
                end
            end
            EXCITING: begin
                if (sample_valid_i) begin
                    if (excited) begin
                        ecnt_d = ecnt_inc[7:0];
                        // >= so a latency lowered mid-run still detects
                        if (ecnt_inc >= {1'b0, lat_eff}) detect = 1'b1;
                    end else begin
                        ecnt_d  = 8'd0;
                        state_d = RELAXED;
                    end
                end
            end
            DELAYING: begin
                dcnt_d = dcnt_q - DLY_W'(1);
                if (dcnt_q == DLY_W'(1)) begin
                    trig_d  = 1'b1;
                    state_d = WAIT_RELAX;
                end
            end
            default: begin
                ecnt_d = 8'd0;
                if (sample_valid_i && relaxed) state_d = RELAXED;
            end
        endcase

        if (detect) begin
            ecnt_d = 8'd0;
            dcnt_d = delay_i;
            if (delay_i == '0) begin
                trig_d  = 1'b1;
                state_d = WAIT_RELAX;
            end else begin
                state_d = DELAYING;
            end
        end

        if (!enable_i) begin
            state_d = WAIT_RELAX;
            trig_d  = 1'b0;
            ecnt_d  = 8'd0;
            dcnt_d  = '0;
        end
    end

    always_comb begin
        pcnt_d   = (&pcnt_q) ? pcnt_q : pcnt_q + DLY_W'(1);
        count_d  = count_q;
        period_d = period_q;
        if (trig_q) begin
            period_d = pcnt_q;
            pcnt_d   = DLY_W'(1);
            count_d  = count_q + 32'd1;
        end
        if (clear_i) begin
            count_d  = 32'd0;
            period_d = '0;
            pcnt_d   = trig_q ? DLY_W'(1) : '0;
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state_q  <= WAIT_RELAX;
            ecnt_q   <= 8'd0;
            dcnt_q   <= '0;
            trig_q   <= 1'b0;
            count_q  <= 32'd0;
            period_q <= '0;
            pcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            ecnt_q   <= ecnt_d;
            dcnt_q   <= dcnt_d;
            trig_q   <= trig_d;
            count_q  <= count_d;
            period_q <= period_d;
            pcnt_q   <= pcnt_d;
        end
    end

    assign trig_o        = trig_q;
    assign state_o       = state_q;
    assign trig_count_o  = count_q;
    assign trig_period_o = period_q;

endmodule

// File: tb/tb_digdar_trigger_gen.sv
// Bench for digdar_trigger_gen: a full-width and an 8-bit-period instance share stimulus;
// an event-time model predicts pulses, state and statistics every cycle.
module tb_digdar_trigger_gen;

    localparam int W = 14;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic                en    = 1'b1;
    logic                clr   = 1'b0;
    logic                vld   = 1'b0;
    logic signed [W-1:0] smp   = '0;
    logic signed [W-1:0] th_ex = '0;
    logic signed [W-1:0] th_rx = '0;
    logic [7:0]          lat   = 8'd1;
    logic [31:0]         dly   = '0;
    logic [7:0]          dly8;

    logic                trig, trig8;
    logic [1:0]          state, state8;
    logic [31:0]         cnt, cnt8;
    logic [31:0]         per;
    logic [7:0]          per8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign dly8 = dly[7:0];

    digdar_trigger_gen #(.WIDTH(W), .DLY_W(32)) dut (
        .adc_clk_i(clk), .adc_rstn_i(rst_n), .enable_i(en), .clear_i(clr),
        .sample_i(smp), .sample_valid_i(vld), .thresh_excite_i(th_ex), .thresh_relax_i(th_rx),
        .latency_i(lat), .delay_i(dly), .trig_o(trig), .state_o(state),
        .trig_count_o(cnt), .trig_period_o(per)
    );

    digdar_trigger_gen #(.WIDTH(W), .DLY_W(8)) dut8 (
        .adc_clk_i(clk), .adc_rstn_i(rst_n), .enable_i(en), .clear_i(clr),
        .sample_i(smp), .sample_valid_i(vld), .thresh_excite_i(th_ex), .thresh_relax_i(th_rx),
        .latency_i(lat), .delay_i(dly8), .trig_o(trig8), .state_o(state8),
        .trig_count_o(cnt8), .trig_period_o(per8)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pulse times as absolute edge numbers, period as distance from a reference edge.
    int     cyc = 0;
    int     m_run, m_fire, m_ref, n, l, s, ex, rx;
    longint m_cnt, m_per;
    bit     m_wait, m_trig, nxt, rise, exc, rlx;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run  = 0;
            m_fire = -1;
            m_wait = 1'b1;
            m_trig = 1'b0;
            m_cnt  = 0;
            m_per  = 0;
            m_ref  = cyc + 1;
        end else begin
            n = cyc;
            if (m_trig) begin
                m_cnt++;
                m_per = n - m_ref;
                m_ref = n;
            end
            if (clr) begin
                m_cnt = 0;
                m_per = 0;
                if (!m_trig) m_ref = n + 1;
            end
            s    = smp;
            ex   = th_ex;
            rx   = th_rx;
            rise = (ex >= rx);
            exc  = rise ? (s >= ex) : (s <= ex);
            rlx  = rise ? (s <= rx) : (s >= rx);
            l    = (lat == 0) ? 1 : int'(lat);
            nxt  = 1'b0;
            if (!en) begin
                m_fire = -1;
                m_wait = 1'b1;
                m_run  = 0;
            end else if (m_fire >= 0) begin
                if (m_fire == n) begin
                    nxt    = 1'b1;
                    m_fire = -1;
                    m_wait = 1'b1;
                end
            end else if (m_wait) begin
                if (vld && rlx) m_wait = 1'b0;
            end else if (vld) begin
                if (exc) begin
                    m_run++;
                    if (m_run >= l) begin
                        m_run = 0;
                        if (dly == 0) begin
                            nxt    = 1'b1;
                            m_wait = 1'b1;
                        end else begin
                            m_fire = n + int'(dly);
                        end
                    end
                end else begin
                    m_run = 0;
                end
            end
            m_trig = nxt;
        end
    end

    function automatic int exp_state();
        if (m_fire >= 0) return 2;
        if (m_wait)      return 3;
        if (m_run > 0)   return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("trig",    trig,   m_trig);
            chk("state",   state,  exp_state());
            chk("count",   cnt,    m_cnt);
            chk("period",  per,    m_per);
            chk("trig8",   trig8,  m_trig);
            chk("state8",  state8, exp_state());
            chk("count8",  cnt8,   m_cnt);
            chk("period8", per8,   (m_per > 255) ? 255 : m_per);
        end
    end

    task automatic drive(input int sv, input bit v);
        smp = W'(sv);
        vld = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fall_vec[5] = '{-60, -60, -10, -60, -60};

        th_ex = 14'sd100;
        th_rx = 14'sd20;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", state, 3);
        chk("rst_trig", trig, 0);
        chk("rst_count", cnt, 0);
        chk("rst_period", per, 0);
        rst_n = 1'b1;

        // rising ramp, latency 1, no delay
        for (int i = 0; i <= 20; i++) begin
            drive(i * 10, 1'b1);
            if (i == 9)  chk("ramp_pre", trig, 0);
            if (i == 10) chk("ramp_pulse", trig, 1);
        end
        repeat (8) drive(200, 1'b1);
        chk("ramp_hold_count", cnt, 1);
        drive(0, 1'b1);
        for (int i = 0; i <= 20; i++) drive(i * 10, 1'b1);
        repeat (3) drive(200, 1'b1);
        chk("ramp2_count", cnt, 2);

        // falling polarity, latency 3, delay 5
        th_ex = -14'sd50;
        th_rx = 14'sd0;
        lat   = 8'd3;
        dly   = 32'd5;
        drive(0, 1'b1);
        foreach (fall_vec[i]) drive(fall_vec[i], 1'b1);
        drive(-60, 1'b1);
        chk("fall_delaying", state, 2);
        for (int j = 1; j <= 5; j++) begin
            drive((j % 2) ? -49 : -51, 1'b1);
            if (j == 4) chk("fall_pre", trig, 0);
        end
        chk("fall_pulse", trig, 1);
        for (int j = 0; j < 10; j++) drive((j % 2) ? -49 : -51, 1'b1);
        chk("fall_wait_state", state, 3);
        chk("fall_count", cnt, 3);
        drive(0, 1'b1);
        chk("fall_relaxed", state, 0);

        // period between two pulses 1000 clocks apart
        th_ex = 14'sd100;
        th_rx = 14'sd20;
        lat   = 8'd1;
        dly   = 32'd0;
        drive(100, 1'b1);
        for (int i = 0; i < 999; i++) drive(0, 1'b1);
        drive(100, 1'b1);
        drive(0, 1'b1);
        chk("period_1000", per, 1000);
        chk("period8_sat", per8, 255);
        chk("period_count", cnt, 5);

        // enable dropped while delaying
        dly = 32'd10;
        drive(100, 1'b1);
        chk("en_delaying", state, 2);
        repeat (3) drive(200, 1'b1);
        en = 1'b0;
        drive(200, 1'b1);
        chk("dis_state", state, 3);
        repeat (4) drive(200, 1'b1);
        en = 1'b1;
        repeat (15) drive(200, 1'b1);
        chk("reen_count", cnt, 5);
        chk("reen_state", state, 3);
        drive(20, 1'b1);
        chk("reen_relaxed", state, 0);
        drive(100, 1'b1);
        for (int i = 0; i < 10; i++) drive(100, 1'b1);
        chk("reen_pulse", trig, 1);
        drive(0, 1'b1);
        chk("reen_count2", cnt, 6);

        // invalid cycles between valid excited samples
        lat = 8'd2;
        dly = 32'd0;
        drive(0, 1'b1);
        drive(150, 1'b1);
        chk("inv_exciting", state, 1);
        drive(0, 1'b0);
        chk("inv_hold", state, 1);
        chk("inv_nopulse", trig, 0);
        drive(150, 1'b1);
        chk("inv_pulse", trig, 1);
        drive(0, 1'b1);

        // latency 0 behaves as 1
        lat = 8'd0;
        drive(100, 1'b1);
        chk("lat0_pulse", trig, 1);
        drive(0, 1'b1);
        chk("lat0_count", cnt, 8);

        // clear coinciding with a pulse, then pcnt restarts at 1
        lat = 8'd1;
        drive(100, 1'b1);
        chk("clr_pulse", trig, 1);
        clr = 1'b1;
        drive(0, 1'b1);
        clr = 1'b0;
        chk("clr_count", cnt, 0);
        chk("clr_period", per, 0);
        chk("clr_period8", per8, 0);
        drive(100, 1'b1);
        drive(0, 1'b1);
        chk("clr_next_period", per, 2);
        chk("clr_next_count", cnt, 1);

        // async reset while a delayed trigger is pending
        dly = 32'd20;
        drive(100, 1'b1);
        repeat (3) drive(0, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_state", state, 3);
        chk("arst_trig", trig, 0);
        chk("arst_count", cnt, 0);
        chk("arst_period", per, 0);
        chk("arst_period8", per8, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) drive(0, 1'b1);
        chk("arst_lost_count", cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/digdar_trigger_gen.md
Name: digdar_trigger_gen

Overview:
- Debounced threshold trigger detector for the digitizer front end.
- Watches one sample stream: fast ADC channel B for radar trigger, or a slow ADC channel for ACP/ARP.
- Emits a one-cycle trigger pulse, optionally delayed, that the capture stage uses as its radar/ACP/ARP trigger input.
- Separate excitation and relaxation thresholds provide hysteresis; the block also keeps a trigger count and the last trigger-to-trigger period for software.

Parameters:
- WIDTH, 14, sample and threshold width (two's complement).
- DLY_W, 32, width of the delay counter and the period counter.

Ports:
- adc_clk_i  in  1  ADC clock; the only clock.
- adc_rstn_i  in  1  reset, asynchronous assert, active-low.
- enable_i  in  1  detector enable.
- clear_i  in  1  synchronous clear of the statistics counters.
- sample_i  in  WIDTH  signed input sample.
- sample_valid_i  in  1  sample_i is valid this cycle.
- thresh_excite_i  in  WIDTH  signed excitation threshold.
- thresh_relax_i  in  WIDTH  signed relaxation threshold.
- latency_i  in  8  consecutive excited valid samples required for detection; 0 is treated as 1.
- delay_i  in  DLY_W  clock cycles from detection to trig_o.
- trig_o  out  1  one-cycle trigger pulse.
- state_o  out  2  current FSM state, for status reads.
- trig_count_o  out  32  trig_o pulses since reset or clear; wraps.
- trig_period_o  out  DLY_W  clock cycles between the last two trig_o pulses.

Behaviour:
- Reset (async, adc_rstn_i=0): state=WAIT_RELAX, trig_o=0, trig_count_o=0, trig_period_o=0, internal counters=0.
- Polarity:
  - Rising when thresh_excite_i >= thresh_relax_i (signed, includes equal): excited means sample >= excite; relaxed means sample <= relax.
  - Falling otherwise: excited means sample <= excite; relaxed means sample >= relax.
  - Thresholds are evaluated live on every valid sample.
- States (state_o encoding 0..3):
  - RELAXED(0): on a valid excited sample, ecnt=1. If ecnt reaches max(latency_i,1), detect; else go to EXCITING.
  - EXCITING(1): on each valid excited sample, ecnt++; detect when ecnt==max(latency_i,1). A valid non-excited sample returns to RELAXED with ecnt=0. Invalid cycles leave the state unchanged.
  - Detect: latch delay_i into dcnt. If delay_i==0, pulse trig_o on the next cycle and go to WAIT_RELAX; else go to DELAYING.
  - DELAYING(2): dcnt-- every clock. When dcnt==1, pulse trig_o on the next cycle and go to WAIT_RELAX. Samples are ignored in this state; relaxation during the delay does not cancel the trigger.
  - WAIT_RELAX(3): a valid relaxed sample returns to RELAXED. No trigger can fire in this state.
- Latency:
  - Sample k completes detection with delay_i=0: trig_o is high in cycle k+1.
  - With delay_i=D (D>=1): trig_o is high in cycle k+1+D.
- trig_o is registered and is never high on two consecutive cycles.
- enable_i=0:
  - Synchronously forces WAIT_RELAX and trig_o=0, and aborts any pending delay.
  - On re-enable, a signal already beyond the excitation threshold must relax before it can trigger.
  - Statistics counters are held.
- Period counter pcnt:
  - Increments every clock and saturates at all-ones.
  - On a trig_o pulse: trig_period_o<=pcnt, pcnt<=1.
  - trig_count_o increments by 1 on the same pulse.
- clear_i=1: trig_count_o=0, trig_period_o=0, pcnt=0. The FSM is unaffected. If clear_i coincides with a trig_o pulse, clear wins for trig_count_o and trig_period_o, and pcnt restarts at 1.
- Threshold or latency_i changes mid-operation take effect on the next valid sample. delay_i is used only at detection.
- Reset mid-delay: the pending trigger is lost and no trig_o pulse is generated.

Test Plan:
- Rising, latency: excite=100, relax=20, latency=1, delay=0; ramp 0→200, step 10, valid every cycle → trig_o exactly one cycle after the sample =100; no second pulse while held at 200. After dropping to 0 and re-ramping → second pulse; trig_count_o=2.
- Falling: excite=-50, relax=0, latency=3, delay=5. Samples -60,-60,-10,-60,-60,-60 → first two excited samples rejected by -10; detection on the third consecutive -60; trig_o at detection cycle +6. Samples oscillating between -49 and -51 after the trigger → no retrigger until a sample >=0.
- Period: two detections 1000 clocks apart, delay=0 → trig_period_o=1000 and trig_count_o=2. Idle 2^DLY_W clocks (reduced DLY_W=8) → next period reads 255 (saturated).
- Enable and sample_valid: enable_i dropped during DELAYING → no trig_o; state_o=3; input held at 200 after re-enable → no trigger until the input goes <=20 and then >=100. Invalid cycles interleaved every other cycle with latency=2 → detection counts only valid samples.
- Reset and clear: async reset asserted mid-delay → all outputs 0 immediately and state_o=3. clear_i asserted in the same cycle as trig_o → trig_count_o=0, trig_period_o=0.
